core_alu_issue: RTL
===================

// Module: core_alu_issue
// PURPOSE
//  Initiator side of the core_alu interface. Accepts one decoded-register RV32I instruction
//  (instr, PC, rs1/rs2 values) via valid/ready, selects ALU operands and ALU code, pulses C_ALU,
//  collects the registered ALU_O one cycle later, then presents result/rd/write-enable/branch
//  outcome via valid/ready to writeback. Sits between register read and writeback.
// PARAMETERS
//  XLEN      32   datapath width; only 32 supported
//  ILL_CODE  10'h3FF  OPCODE_ALU driven for illegal instructions
// PORTS
//  CLK          in   1   clock, all state on posedge
//  RST          in   1   synchronous, active-high reset
//  IN_VALID     in   1   instruction bundle valid
//  IN_READY     out  1   block can accept a bundle (IDLE only)
//  IN_INSTR     in   32  instruction word
//  IN_PC        in   32  instruction address
//  IN_RS1       in   32  rs1 value
//  IN_RS2       in   32  rs2 value
//  C_ALU        out  1   ALU capture enable, one-cycle pulse
//  OPCODE_ALU   out  10  ALU code {funct7,funct3}-style, see BEHAVIOUR
//  ALU_I1       out  32  ALU operand 1
//  ALU_I2       out  32  ALU operand 2
//  ALU_O        in   32  registered ALU result
//  RES_VALID    out  1   result bundle valid
//  RES_READY    in   1   consumer accepts result
//  RES_DATA     out  32  result / link value / memory address
//  RES_RD       out  5   destination register
//  RES_WE       out  1   write RES_DATA to RES_RD
//  RES_BR_TAKEN out  1   branch condition true (BRANCH only, else 0)
//  RES_ILLEGAL  out  1   instruction not supported
// BEHAVIOUR
//  Reset: state IDLE; IN_READY, C_ALU, RES_* and OPCODE_ALU/ALU_I1/ALU_I2 all 0. RST wins in any
//   state, incl. mid-EXEC/RESP: in-flight instruction dropped, no RES_VALID.
//  FSM: IDLE --(IN_VALID&IN_READY)--> EXEC (or RESP if illegal) ; EXEC --> WAIT ; WAIT --> RESP ;
//   RESP --(RES_READY)--> IDLE. IN_READY=1 only in IDLE (outside reset). Min 4 cycles/instr.
//  Accept cycle registers OPCODE_ALU, ALU_I1, ALU_I2, rd, class; held stable until next accept.
//  EXEC: C_ALU=1 exactly one cycle. WAIT: ALU_O now holds result; RES_* registered from it.
//  RESP: RES_VALID=1; all RES_* stable while RES_READY=0. Illegal: no C_ALU, RES_DATA=0.
//  Codes: SUM 000 SUB 100 SLL 001 SLT 002 SLTU 003 XOR 004 SRL 005 SRA 105 OR 006 AND 007 (hex).
//  Decode (opcode[6:0]):
//   OP 0110011: I1=rs1 I2=rs2 code {f7,f3}; f7 must be 0, or 0100000 with f3 000/101; WE=1
//   OP-IMM 0010011: I1=rs1 I2=sext(imm_i), code {7'b0,f3}; f3=001 needs f7=0; f3=101 code
//    {f7,101}, f7 in {0,0100000}; shifts I2={27'b0,shamt}; WE=1
//   LUI: I1=0 I2=imm_u SUM; AUIPC: I1=PC I2=imm_u SUM; WE=1
//   JAL/JALR: I1=PC I2=4 SUM (link); WE=1
//   LOAD: I1=rs1 I2=sext(imm_i); STORE: I2=sext(imm_s); SUM; WE=0, RES_DATA=address
//   BRANCH: I1=rs1 I2=rs2; BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU; f3 010/011 illegal; WE=0
//    taken: BEQ ALU_O==0, BNE !=0, BLT/BLTU ALU_O[0], BGE/BGEU !ALU_O[0]
//   anything else: illegal, OPCODE_ALU=ILL_CODE, WE=0
//  rd==0 forces RES_WE=0. RES_RD=instr[11:7] always. Adds wrap mod 2^32 (done in ALU).
// TESTING
//  ADD 0x002081B3, rs1=5 rs2=7 -> C_ALU pulse cycle+1, code 000, RES_DATA=12 RD=3 WE=1 @cycle+3
//  SRAI 0x40435293, rs1=0x80000000 -> code 105, I2=4, RES_DATA=0xF8000000, RD=5 WE=1
//  BNE rs1=rs2=9 -> code 100, TAKEN=0 WE=0; BLTU rs1=1 rs2=0xFFFFFFFF -> code 003, TAKEN=1
//  RES_READY=0 for 5 cycles -> RES_* stable, IN_READY=0, exactly one C_ALU pulse; then IDLE
//  RST asserted during EXEC -> next cycle all outputs 0, no RES_VALID, IN_READY=1 after release
//  IN_INSTR=0x0000007F -> no C_ALU, OPCODE_ALU=3FF, RES_ILLEGAL=1, RES_DATA=0, WE=0

Source files
------------

// File: rtl/core_alu_issue.sv
// Issue stage between register read and writeback: decodes one RV32I bundle, drives the
// core_alu operands/code, pulses C_ALU, and returns the registered result with valid/ready.
module core_alu_issue #(
  parameter int unsigned XLEN     = 32,
  parameter logic [9:0]  ILL_CODE = 10'h3FF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     IN_INSTR,
  input  logic [XLEN-1:0] IN_PC,
  input  logic [XLEN-1:0] IN_RS1,
  input  logic [XLEN-1:0] IN_RS2,
  output logic            C_ALU,
  output logic [9:0]      OPCODE_ALU,
  output logic [XLEN-1:0] ALU_I1,
  output logic [XLEN-1:0] ALU_I2,
  input  logic [XLEN-1:0] ALU_O,
  output logic            RES_VALID,
  input  logic            RES_READY,
  output logic [XLEN-1:0] RES_DATA,
  output logic [4:0]      RES_RD,
  output logic            RES_WE,
  output logic            RES_BR_TAKEN,
  output logic            RES_ILLEGAL
);

  localparam logic [9:0] CodeSum  = 10'h000;
  localparam logic [9:0] CodeSub  = 10'h100;
  localparam logic [9:0] CodeSlt  = 10'h002;
  localparam logic [9:0] CodeSltu = 10'h003;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [6:0] F7Zero = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Instruction fields
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opc   = IN_INSTR[6:0];
  assign f3    = IN_INSTR[14:12];
  assign f7    = IN_INSTR[31:25];
  assign rd    = IN_INSTR[11:7];
  assign imm_i = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
  assign imm_s = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
  assign imm_u = {IN_INSTR[31:12], 12'b0};
  assign shamt = {27'b0, IN_INSTR[24:20]};

  // Decoded bundle
  logic [9:0]      dec_code;
  logic [XLEN-1:0] dec_i1;
  logic [XLEN-1:0] dec_i2;
  logic            dec_we;
  logic            dec_branch;
  logic            dec_illegal;

  always_comb begin
    dec_code    = CodeSum;
    dec_i1      = '0;
    dec_i2      = '0;
    dec_we      = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;

    case (opc)
      OpcOp: begin
        dec_i1   = IN_RS1;
        dec_i2   = IN_RS2;
        dec_code = {f7, f3};
        dec_we   = 1'b1;
        if (!(f7 == F7Zero || (f7 == F7Alt && (f3 == 3'b000 || f3 == 3'b101)))) begin
          dec_illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        dec_i1   = IN_RS1;
        dec_i2   = imm_i;
        dec_code = {7'b0, f3};
        dec_we   = 1'b1;
        if (f3 == 3'b001) begin
          dec_i2 = shamt;
          if (f7 != F7Zero) dec_illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          // Arithmetic vs logical right shift is carried in the immediate's top bits
          dec_i2   = shamt;
          dec_code = {f7, f3};
          if (f7 != F7Zero && f7 != F7Alt) dec_illegal = 1'b1;
        end
      end
      OpcLui: begin
        dec_i1 = '0;
        dec_i2 = imm_u;
        dec_we = 1'b1;
      end
      OpcAuipc: begin
        dec_i1 = IN_PC;
        dec_i2 = imm_u;
        dec_we = 1'b1;
      end
      OpcJal, OpcJalr: begin
        dec_i1 = IN_PC;
        dec_i2 = 32'd4;
        dec_we = 1'b1;
      end
      OpcLoad: begin
        dec_i1 = IN_RS1;
        dec_i2 = imm_i;
      end
      OpcStore: begin
        dec_i1 = IN_RS1;
        dec_i2 = imm_s;
      end
      OpcBranch: begin
        dec_i1     = IN_RS1;
        dec_i2     = IN_RS2;
        dec_branch = 1'b1;
        case (f3)
          3'b000, 3'b001: dec_code = CodeSub;
          3'b100, 3'b101: dec_code = CodeSlt;
          3'b110, 3'b111: dec_code = CodeSltu;
          default:        dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase

    if (dec_illegal) begin
      dec_code   = ILL_CODE;
      dec_i1     = '0;
      dec_i2     = '0;
      dec_we     = 1'b0;
      dec_branch = 1'b0;
    end
    if (rd == 5'd0) dec_we = 1'b0;
  end

  logic accept;
  assign accept = (state_q == StIdle) && IN_VALID;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (IN_VALID) state_d = dec_illegal ? StResp : StExec;
      end
      StExec: state_d = StWait;
      StWait: state_d = StResp;
      StResp: begin
        if (RES_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign IN_READY  = (state_q == StIdle) && !RST;
  assign C_ALU     = (state_q == StExec) && !RST;
  assign RES_VALID = (state_q == StResp) && !RST;

  // Per-instruction context kept for the result phase
  logic [9:0]      opcode_q;
  logic [XLEN-1:0] i1_q;
  logic [XLEN-1:0] i2_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic            branch_q;
  logic [2:0]      f3_q;

  logic [XLEN-1:0] res_data_q;
  logic [4:0]      res_rd_q;
  logic            res_we_q;
  logic            res_taken_q;
  logic            res_illegal_q;

  logic            br_cond;

  always_comb begin
    br_cond = 1'b0;
    case (f3_q)
      3'b000:         br_cond = (ALU_O == '0);
      3'b001:         br_cond = (ALU_O != '0);
      3'b100, 3'b110: br_cond = ALU_O[0];
      3'b101, 3'b111: br_cond = !ALU_O[0];
      default:        br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      opcode_q      <= '0;
      i1_q          <= '0;
      i2_q          <= '0;
      rd_q          <= '0;
      we_q          <= 1'b0;
      branch_q      <= 1'b0;
      f3_q          <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_we_q      <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q <= dec_code;
        i1_q     <= dec_i1;
        i2_q     <= dec_i2;
        rd_q     <= rd;
        we_q     <= dec_we;
        branch_q <= dec_branch;
        f3_q     <= f3;
        // Illegal bundles skip the ALU, so their result is formed right away
        if (dec_illegal) begin
          res_data_q    <= '0;
          res_rd_q      <= rd;
          res_we_q      <= 1'b0;
          res_taken_q   <= 1'b0;
          res_illegal_q <= 1'b1;
        end
      end
      if (state_q == StWait) begin
        res_data_q    <= ALU_O;
        res_rd_q      <= rd_q;
        res_we_q      <= we_q;
        res_taken_q   <= branch_q && br_cond;
        res_illegal_q <= 1'b0;
      end
    end
  end

  assign OPCODE_ALU   = opcode_q;
  assign ALU_I1       = i1_q;
  assign ALU_I2       = i2_q;
  assign RES_DATA     = res_data_q;
  assign RES_RD       = res_rd_q;
  assign RES_WE       = res_we_q;
  assign RES_BR_TAKEN = res_taken_q;
  assign RES_ILLEGAL  = res_illegal_q;

endmodule
